// File: rtl/i2c_master_write_byte.sv
// ----------------------------------------------------------------------------
// i2c_master_write_byte
//
// Byte-level write sequencer placed in front of the I2C bit writer. A request
// can contain a START bit, DATA_WIDTH data bits and a STOP bit, and each part
// is optional. The block issues one bit-writer command per bit, moves on at
// every bit_finish pulse and reports completion with a one-cycle finish pulse.
//
// Ports:
//   clock, reset_n  - system clock and asynchronous active-low reset
//   go              - request strobe, only looked at while busy=0
//   send_start      - request includes a START bit
//   send_data       - request includes DATA_WIDTH data bits
//   send_stop       - request includes a STOP bit
//   data_in         - data to send, captured together with go
//   busy            - a sequence is in progress
//   finish          - one-cycle completion pulse
//   bit_go          - go to the bit writer
//   bit_command     - command to the bit writer (lookahead, see below)
//   bit_finish      - per-bit finish pulse from the bit writer
// ----------------------------------------------------------------------------
module i2c_master_write_byte #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MSB_FIRST  = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  go,
   input  logic                  send_start,
   input  logic                  send_data,
   input  logic                  send_stop,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  busy,
   output logic                  finish,
   output logic                  bit_go,
   output logic [2:0]            bit_command,
   input  logic                  bit_finish
);

   localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

   localparam logic [2:0] CmdIdle  = 3'b000;
   localparam logic [2:0] CmdStart = 3'b010;
   localparam logic [2:0] CmdStop  = 3'b011;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e                state_q, state_d;
   logic                  finish_q, finish_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  data_en_q, data_en_d;
   logic                  stop_en_q, stop_en_d;

   // Index 0 is the MSB when MSB_FIRST is set, otherwise the LSB.
   function automatic logic sel_bit(input logic [DATA_WIDTH-1:0] d,
                                    input logic [IdxW-1:0]       idx);
      logic [DATA_WIDTH-1:0] sh;
      if (MSB_FIRST != 0) begin
         sh = d << idx;
         return sh[DATA_WIDTH-1];
      end else begin
         sh = d >> idx;
         return sh[0];
      end
   endfunction

   function automatic logic [2:0] data_cmd(input logic b);
      return {2'b10, b};
   endfunction

   // bit_command is a lookahead: while bit_finish is high it already shows the
   // command for the next bit (or IDLE), so the bit writer picks it up on the
   // edge that ends the current bit and never sees a stale START/STOP.
   always_comb begin
      state_d     = state_q;
      finish_d    = 1'b0;
      idx_d       = idx_q;
      data_d      = data_q;
      data_en_d   = data_en_q;
      stop_en_d   = stop_en_q;
      bit_command = CmdIdle;

      unique case (state_q)
         StIdle: begin
            if (go) begin
               data_d    = data_in;
               data_en_d = send_data;
               stop_en_d = send_stop;
               idx_d     = '0;
               if (send_start) begin
                  state_d     = StStart;
                  bit_command = CmdStart;
               end else if (send_data) begin
                  state_d     = StData;
                  bit_command = data_cmd(sel_bit(data_in, '0));
               end else if (send_stop) begin
                  state_d     = StStop;
                  bit_command = CmdStop;
               end else begin
                  // Empty request: complete at once without touching the bus.
                  finish_d = 1'b1;
               end
            end
         end

         StStart: begin
            if (!bit_finish) begin
               bit_command = CmdStart;
            end else if (data_en_q) begin
               state_d     = StData;
               bit_command = data_cmd(sel_bit(data_q, '0));
            end else if (stop_en_q) begin
               state_d     = StStop;
               bit_command = CmdStop;
            end else begin
               state_d  = StIdle;
               finish_d = 1'b1;
            end
         end

         StData: begin
            if (!bit_finish) begin
               bit_command = data_cmd(sel_bit(data_q, idx_q));
            end else if (idx_q == LastIdx) begin
               if (stop_en_q) begin
                  state_d     = StStop;
                  bit_command = CmdStop;
               end else begin
                  state_d  = StIdle;
                  finish_d = 1'b1;
               end
            end else begin
               idx_d       = idx_q + IdxW'(1);
               bit_command = data_cmd(sel_bit(data_q, idx_q + IdxW'(1)));
            end
         end

         StStop: begin
            if (!bit_finish) begin
               bit_command = CmdStop;
            end else begin
               state_d  = StIdle;
               finish_d = 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         finish_q  <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         data_en_q <= 1'b0;
         stop_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         finish_q  <= finish_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         data_en_q <= data_en_d;
         stop_en_q <= stop_en_d;
      end
   end

   // Every non-idle state drives a bit, so busy and bit_go coincide.
   assign bit_go = (state_q != StIdle);
   assign busy   = bit_go;
   assign finish = finish_q;

endmodule

// File: doc/i2c_master_write_byte.md
Name: i2c_master_write_byte

Overview:
- Byte-level write sequencer sitting directly upstream of the I2C master bit writer.
- Accepts a write request (optional START, optional data byte, optional STOP) from the transaction controller.
- Issues the matching sequence of per-bit commands (go/command) to the bit writer and advances on each bit-writer finish pulse.
- Reports completion to the controller with a one-cycle finish pulse. ACK/NACK sampling is out of scope; it belongs to the read path.

Parameters:
- DATA_WIDTH, 8, number of data bits sent per request.
- MSB_FIRST, 1, 1 sends data_in[DATA_WIDTH-1] first; 0 sends data_in[0] first.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- go  input  1  request strobe; sampled only while busy=0
- send_start  input  1  request includes START bit (sampled with go)
- send_data  input  1  request includes DATA_WIDTH data bits (sampled with go)
- send_stop  input  1  request includes STOP bit (sampled with go)
- data_in  input  DATA_WIDTH  byte to send (sampled with go)
- busy  output  1  high from the acceptance edge until the finish edge
- finish  output  1  one-cycle completion pulse
- bit_go  output  1  go to the bit writer
- bit_command  output  3  command to the bit writer
- bit_finish  input  1  finish pulse from the bit writer

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - state=IDLE, busy=0, finish=0, bit_go=0.
  - Bit index=0, data shift register=0.
  - bit_command=IDLE (3'b000). The bit writer holds its lines on IDLE.
- Command encodings: IDLE 3'b000, START 3'b010, STOP 3'b011, DATA_0 3'b100, DATA_1 3'b101. No other codes are ever driven.
- States: IDLE, S_START, S_DATA, S_STOP.
  - IDLE: bit_go=0. On an edge with go=1, latch data_in, flags and index=0, then set busy=1.
  - Next state on acceptance is the first enabled phase, in order START, DATA, STOP. bit_go<=1 if any phase is enabled.
  - All flags 0: stay IDLE, busy stays 0, finish<=1 on the acceptance edge (pulse in the next cycle).
- In S_START, S_DATA and S_STOP, bit_go is held at 1 continuously. The block advances only on edges where bit_finish=1.
  - S_START: on bit_finish, go to S_DATA if send_data, else S_STOP if send_stop, else done.
  - S_DATA: on bit_finish, if index=DATA_WIDTH-1, go to S_STOP if send_stop, else done. Otherwise index<=index+1.
  - S_STOP: on bit_finish, done.
  - Done: state<=IDLE, bit_go<=0, busy<=0, finish<=1 for exactly one cycle.
- bit_command is combinational lookahead, so the bit writer samples the next command on the edge that ends the current bit (no START/STOP glitch):
  - bit_finish=0: command of the current phase. S_DATA gives DATA_1 or DATA_0 from the selected data bit at the current index.
  - bit_finish=1: command of the phase/bit that follows, or IDLE if the sequence ends.
  - In IDLE: IDLE, except that on the cycle go is accepted it is the first phase's command.
- Data bit order: index 0 selects the MSB when MSB_FIRST=1, the LSB when MSB_FIRST=0.
- go, flags and data_in are ignored while busy=1. A mid-sequence change of inputs has no effect.
- A bit_finish pulse in IDLE is ignored.
- With bit_go held, each bit spans 9 clock cycles of the bit writer. finish follows the last bit_finish by 1 cycle.

Test Plan:
- Reset during S_DATA at index 4 -> next cycle busy=0, bit_go=0, bit_command=000. A subsequent request then runs normally from index 0.
- go with start=1, data=1, stop=0, data_in=8'hA5, MSB_FIRST=1 -> bit_command sequence 010,101,100,101,100,100,101,100,101. Exactly 9 bit_finish pulses, then a one-cycle finish, bit_go=0, bit_command=000.
- go with start=0, data=1, stop=1, data_in=8'h01 -> seven 100 then 101 then 011. finish pulses once after the 9th bit_finish.
- go with stop only -> one STOP bit (011) of 9 cycles, then finish. During the bit_finish cycle, bit_command is already 000 (lookahead).
- go with all flags 0 -> finish pulses one cycle later, bit_go never asserts, busy stays 0.
- Extra pulses of go and changes to data_in while busy, plus a spurious bit_finish in IDLE -> sequence unchanged, no extra finish pulse.
